bt_cmd_frame_rx: RTL
====================

BT_CMD_FRAME_RX -- requirements
Module: bt_cmd_frame_rx

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of 8-bit command channels per frame (legal range 1..8).
REQ-002 SHALL have parameter SOF, default 8'hA5, meaning the start-of-frame byte.
REQ-003 SHALL have parameter GAP_CYC, default 2_000_000, meaning the maximum clock cycles allowed between bytes inside a frame.
REQ-004 SHALL have parameter WDOG_CYC, default 50_000_000, meaning the cycles without a valid frame before the link is declared lost.
REQ-005 SHALL have parameter SAFE_VAL, default all-zero (width NUM_CH*8), meaning the command value forced on reset and on link loss.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port rx_data, input, 8 bits: received byte from the UART receiver.
REQ-009 SHALL have port rx_data_rdy, input, 1 bit: one-cycle strobe qualifying rx_data.
REQ-010 SHALL have port cmd_bus, output, NUM_CH*8 bits: latched channel commands; channel 0 occupies [7:0].
REQ-011 SHALL have port cmd_valid, output, 1 bit: one-cycle pulse when cmd_bus is updated from a good frame.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a checksum or gap error.
REQ-013 SHALL have port link_ok, output, 1 bit: high while the watchdog has not expired.
REQ-014 SHALL have port err_cnt, output, 8 bits: saturating count of frame errors.

Function
REQ-015 SHALL define a frame as SOF, then NUM_CH payload bytes, then one checksum byte equal to the XOR of all payload bytes.
REQ-016 SHALL use FSM states IDLE, PAYLOAD and CHECK.
REQ-017 In IDLE, SHALL discard every byte except SOF; on SOF it SHALL clear the byte index and running XOR and go to PAYLOAD.
REQ-018 In PAYLOAD, SHALL store each byte into the shadow register at the current index and XOR it into the running checksum.
REQ-019 In PAYLOAD, SHALL move to CHECK after byte NUM_CH-1; a byte equal to SOF SHALL be treated as ordinary data.
REQ-020 In CHECK, on a checksum byte, SHALL return to IDLE.
REQ-021 If the checksum matches, cmd_bus SHALL load the shadow register and cmd_valid SHALL pulse, both in the cycle after the checksum strobe.
REQ-022 If the checksum mismatches, SHALL leave cmd_bus unchanged and pulse frame_err with the same one-cycle latency.
REQ-023 In PAYLOAD or CHECK, SHALL count cycles since the last strobe; on reaching GAP_CYC it SHALL pulse frame_err and go to IDLE, discarding partial data.
REQ-024 The gap counter SHALL reset on every strobe and SHALL be idle in IDLE.
REQ-025 The watchdog counter SHALL reset to 0 on every good-frame commit and otherwise increment, saturating at WDOG_CYC.
REQ-026 When the watchdog reaches WDOG_CYC, link_ok SHALL go low and cmd_bus SHALL load SAFE_VAL in the same cycle, without a cmd_valid pulse.
REQ-027 A subsequent good frame SHALL restore link_ok high in the same cycle as its cmd_valid.
REQ-028 If watchdog expiry and a good-frame commit coincide, the commit SHALL win: cmd_bus takes the frame, link_ok stays high and the watchdog clears.
REQ-029 err_cnt SHALL increment on each frame_err pulse and hold at 255.
REQ-030 cmd_valid and frame_err SHALL never be high in the same cycle.
REQ-031 rx_data_rdy SHALL be sampled every cycle; back-to-back strobes on consecutive cycles SHALL be accepted.

Reset
REQ-032 While rst is low, the block SHALL hold: FSM=IDLE, cmd_bus=SAFE_VAL, cmd_valid=0, frame_err=0, link_ok=0, err_cnt=0, and all counters and shadow registers at 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no frame_err pulse.
REQ-034 link_ok SHALL remain low after reset until the first good frame.

Structure
REQ-035 Shared package bt_frame_pkg SHALL hold the FSM state encoding, the default SOF constant, and the checksum-width constant.
REQ-036 The watchdog and the gap timer SHALL each be an instance of one sub-module, bt_timeout_cnt (parameter LIMIT; ports clk, rst, clr, en, expired).
REQ-037 Counter widths SHALL be $clog2(LIMIT+1).

Verification
REQ-038 With NUM_CH=2, send A5,12,34,26 -> one cycle after the last strobe, cmd_bus=16'h3412, cmd_valid pulses once, link_ok=1.
REQ-039 Send A5,12,34,00 -> frame_err pulses once, cmd_bus unchanged, err_cnt increments by 1.
REQ-040 Send A5,12, then GAP_CYC idle cycles, then A5,01,02,03 -> frame_err pulses once at the gap, after which cmd_bus=16'h0201.
REQ-041 Send A5,A5,A5,00 -> accepted as good (payload A5,A5; checksum 00), cmd_bus=16'hA5A5.
REQ-042 After a good frame, stay idle WDOG_CYC cycles -> link_ok falls and cmd_bus=SAFE_VAL; then land a good frame exactly on the expiry cycle -> commit wins.
REQ-043 Send 300 bad frames -> err_cnt saturates at 255; assert rst mid-frame -> all outputs return to their reset values with no frame_err.

Source files
------------

// File: rtl/bt_frame_pkg.sv
// Shared definitions for the command-frame receiver: FSM encoding,
// default start-of-frame byte and checksum width.
package bt_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } frame_state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
  localparam int         CSUM_W      = 8;

endpackage

// File: rtl/bt_timeout_cnt.sv
// Saturating cycle counter; expired pulses for one cycle as the count
// reaches LIMIT, so the consumer's registered reaction lands on that cycle.
module bt_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int             W    = $clog2(LIMIT + 1);
  localparam logic [W-1:0]   TOP  = W'(LIMIT);
  localparam logic [W-1:0]   LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (en && cnt != TOP)  cnt <= cnt + W'(1);
  end

  // A clear in the same cycle always beats expiry.
  assign expired = en && !clr && (cnt == LAST);

endmodule

// File: rtl/bt_cmd_frame_rx.sv
// UART command-frame receiver: SOF, NUM_CH payload bytes, XOR checksum.
// Latches good frames onto cmd_bus and falls back to SAFE_VAL on link loss.
module bt_cmd_frame_rx
  import bt_frame_pkg::*;
#(
  parameter int                  NUM_CH   = 2,
  parameter logic [7:0]          SOF      = SOF_DEFAULT,
  parameter int                  GAP_CYC  = 2_000_000,
  parameter int                  WDOG_CYC = 50_000_000,
  parameter logic [NUM_CH*8-1:0] SAFE_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_data_rdy,
  output logic [NUM_CH*8-1:0] cmd_bus,
  output logic                cmd_valid,
  output logic                frame_err,
  output logic                link_ok,
  output logic [7:0]          err_cnt
);

  localparam int               IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  frame_state_t             state;
  logic [IDX_W-1:0]         idx;
  logic [CSUM_W-1:0]        csum;
  logic [NUM_CH-1:0][7:0]   shadow;

  logic gap_exp, wdog_exp, sum_ok, commit, err_hit;

  assign sum_ok  = (rx_data == csum);
  assign commit  = rx_data_rdy && (state == CHECK) && sum_ok;
  assign err_hit = gap_exp || (rx_data_rdy && (state == CHECK) && !sum_ok);

  bt_timeout_cnt #(.LIMIT(GAP_CYC)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .clr     (rx_data_rdy || (state == IDLE)),
    .en      (state != IDLE),
    .expired (gap_exp)
  );

  bt_timeout_cnt #(.LIMIT(WDOG_CYC)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (commit),
    .en      (1'b1),
    .expired (wdog_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      csum      <= '0;
      shadow    <= '0;
      cmd_bus   <= SAFE_VAL;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      link_ok   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      cmd_valid <= commit;
      frame_err <= err_hit;
      if (err_hit && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      // Commit has priority over a coincident watchdog expiry.
      if (commit) begin
        cmd_bus <= shadow;
        link_ok <= 1'b1;
      end else if (wdog_exp) begin
        cmd_bus <= SAFE_VAL;
        link_ok <= 1'b0;
      end

      if (gap_exp) begin
        state <= IDLE;
      end else if (rx_data_rdy) begin
        unique case (state)
          IDLE: if (rx_data == SOF) begin
            idx   <= '0;
            csum  <= '0;
            state <= PAYLOAD;
          end
          PAYLOAD: begin
            shadow[idx] <= rx_data;
            csum        <= csum ^ rx_data;
            if (idx == IDX_LAST) state <= CHECK;
            else                 idx   <= idx + IDX_W'(1);
          end
          CHECK:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
